// File: rtl/reg_serializer_pkg.sv
// Shared definitions for the register serializer.
//   ST_IDLE / ST_SHIFT : state encoding values
//   state_e            : FSM state type built on those values
//   cnt_width(n)       : counter width able to hold 0..n-1, never narrower than 1 bit
package reg_serializer_pkg;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   typedef enum logic {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT
   } state_e;

   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/reg_serializer_if.sv
// Load and serial handshake bundle of the register serializer.
//   d, load_valid, load_ready           : parallel load handshake
//   ser_out, ser_valid, ser_last,
//   ser_ready                           : serial output handshake with backpressure
// slave is the serializer's view, master is the view of whatever drives it.
interface reg_serializer_if #(
   parameter int size = 8
);
   logic [size-1:0] d;
   logic            load_valid;
   logic            load_ready;
   logic            ser_out;
   logic            ser_valid;
   logic            ser_last;
   logic            ser_ready;

   modport master (
      output d, load_valid, ser_ready,
      input  load_ready, ser_out, ser_valid, ser_last
   );

   modport slave (
      input  d, load_valid, ser_ready,
      output load_ready, ser_out, ser_valid, ser_last
   );
endinterface

// File: rtl/reg_serializer_ser_bit_counter.sv
// Bit position counter for the serializer.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : return to 0 (wins over inc)
//   inc        : advance by one; saturates at size-1
//   count      : current bit position 0..size-1
//   at_last    : count is at size-1
module ser_bit_counter
   import reg_serializer_pkg::*;
#(
   parameter  int size = 8,
   localparam int CW   = cnt_width(size)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          at_last
);

   localparam logic [CW-1:0] LAST = CW'(size - 1);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && !at_last) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count   = count_q;
   assign at_last = (count_q == LAST);

endmodule

// File: rtl/reg_serializer.sv
// Parallel-to-serial converter: accepts a word over a valid/ready load
// handshake and emits it one bit per accepted serial beat. A new word may be
// accepted on the last beat of the current one, so words stream gap-free.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : load and serial handshake (slave view)
//
// state | meaning
// IDLE  | no word held; load_ready=1, ser_valid=0
// SHIFT | word in flight; ser_out is the bit at the output end of shreg
module reg_serializer
   import reg_serializer_pkg::*;
#(
   parameter int size      = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic         clk,
   input logic         rst_n,
   reg_serializer_if.slave bus
);

   localparam int            CW   = cnt_width(size);
   localparam logic [CW-1:0] LAST = CW'(size - 1);

   state_e          state_q, state_d;
   logic [size-1:0] shreg_q, shreg_d;
   logic [CW-1:0]   count;
   logic            at_last;
   logic            cnt_clr;
   logic            cnt_inc;
   logic            ser_valid;
   logic            beat;

   ser_bit_counter #(.size(size)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (cnt_clr),
      .inc     (cnt_inc),
      .count   (count),
      .at_last (at_last)
   );

   // Outputs come only from registered state; d never reaches ser_*.
   assign ser_valid      = (state_q == SHIFT);
   assign beat           = ser_valid && bus.ser_ready;
   assign bus.ser_valid  = ser_valid;
   assign bus.ser_last   = ser_valid && (count == LAST);
   assign bus.ser_out    = ser_valid && (MSB_FIRST ? shreg_q[size-1] : shreg_q[0]);
   assign bus.load_ready = (state_q == IDLE) || (ser_valid && at_last && bus.ser_ready);

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.load_valid) begin
               shreg_d = bus.d;
               cnt_clr = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (beat) begin
               if (!at_last) begin
                  shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                  cnt_inc = 1'b1;
               end else if (bus.load_valid) begin
                  // last beat doubles as the load slot of the next word
                  shreg_d = bus.d;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_clr = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
      end
   end

endmodule

// File: tb/tb_reg_serializer.sv
// Bench for reg_serializer: three instances (8-bit MSB-first, 8-bit LSB-first,
// 1-bit) share one stimulus stream; each is tracked by a word/bit-index model.
module tb_reg_serializer;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       lv_i  = 1'b0;
   logic [7:0] d_i   = 8'h00;
   logic       sr_i  = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   reg_serializer_if #(.size(8)) if0 ();
   reg_serializer_if #(.size(8)) if1 ();
   reg_serializer_if #(.size(1)) if2 ();

   assign if0.d = d_i;
   assign if0.load_valid = lv_i;
   assign if0.ser_ready = sr_i;
   assign if1.d = d_i;
   assign if1.load_valid = lv_i;
   assign if1.ser_ready = sr_i;
   assign if2.d = d_i[0];
   assign if2.load_valid = lv_i;
   assign if2.ser_ready = sr_i;

   reg_serializer #(.size(8), .MSB_FIRST(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   reg_serializer #(.size(8), .MSB_FIRST(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   reg_serializer #(.size(1), .MSB_FIRST(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

   logic obs_v[3];
   logic obs_o[3];
   logic obs_l[3];
   logic obs_r[3];

   // Model: a held word plus the index of the bit currently presented.
   int         sz[3]  = '{8, 8, 1};
   bit         msb[3] = '{1'b1, 1'b0, 1'b1};
   bit         m_busy[3];
   logic [7:0] m_word[3];
   int         m_idx[3];

   typedef struct {
      logic       lv;
      logic [7:0] d;
      logic       sr;
      logic       v;
      logic       o;
      logic       l;
      logic       r;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic sample();
      obs_v[0] = if0.ser_valid; obs_o[0] = if0.ser_out; obs_l[0] = if0.ser_last; obs_r[0] = if0.load_ready;
      obs_v[1] = if1.ser_valid; obs_o[1] = if1.ser_out; obs_l[1] = if1.ser_last; obs_r[1] = if1.load_ready;
      obs_v[2] = if2.ser_valid; obs_o[2] = if2.ser_out; obs_l[2] = if2.ser_last; obs_r[2] = if2.load_ready;
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         m_busy[k] = 1'b0;
         m_word[k] = 8'h00;
         m_idx[k]  = 0;
      end
   endfunction

   function automatic logic m_last(input int k);
      return logic'(m_busy[k] && (m_idx[k] == sz[k] - 1));
   endfunction

   function automatic logic m_bit(input int k);
      if (!m_busy[k]) return 1'b0;
      return m_word[k][msb[k] ? (sz[k] - 1 - m_idx[k]) : m_idx[k]];
   endfunction

   function automatic void model_update(input int k, input logic lv, input logic [7:0] dv, input logic sr);
      bit last = m_last(k);
      bit rdy  = !m_busy[k] || (last && sr);
      if (m_busy[k] && sr && !last) begin
         m_idx[k]++;
      end else if (lv && rdy) begin
         m_busy[k] = 1'b1;
         m_word[k] = dv;
         m_idx[k]  = 0;
      end else if (m_busy[k] && sr && last) begin
         m_busy[k] = 1'b0;
      end
   endfunction

   task automatic check_reset_values(input string tag);
      sample();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s_u%0d_ser_valid", tag, k), obs_v[k], 1'b0);
         chk($sformatf("%s_u%0d_ser_out", tag, k), obs_o[k], 1'b0);
         chk($sformatf("%s_u%0d_ser_last", tag, k), obs_l[k], 1'b0);
         chk($sformatf("%s_u%0d_load_ready", tag, k), obs_r[k], 1'b1);
      end
   endtask

   // One clock: drive at negedge, check all instances against the model, advance the model at posedge.
   task automatic step(input logic lv, input logic [7:0] dv, input logic sr);
      @(negedge clk);
      lv_i = lv;
      d_i  = dv;
      sr_i = sr;
      #1;
      sample();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("model_u%0d_ser_valid", k), obs_v[k], logic'(m_busy[k]));
         chk($sformatf("model_u%0d_ser_out", k), obs_o[k], m_bit(k));
         chk($sformatf("model_u%0d_ser_last", k), obs_l[k], m_last(k));
         chk($sformatf("model_u%0d_load_ready", k), obs_r[k], logic'(!m_busy[k] || (m_last(k) && sr)));
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_update(k, lv, dv, sr);
   endtask

   initial begin
      logic [7:0] a5  = 8'hA5;
      logic [7:0] c3  = 8'hC3;
      logic [7:0] x81 = 8'h81;
      int beats;
      int lasts;
      int readies;

      model_reset();
      #2;
      check_reset_values("reset");
      #10;
      rst_n = 1'b1;

      // Table: idle hold, then 8'hA5 on the MSB-first instance.
      for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      for (int i = 0; i < 8; i++)
         tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, a5[7-i], logic'(i == 7), logic'(i == 7)});
      tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      foreach (tbl[i]) begin
         step(tbl[i].lv, tbl[i].d, tbl[i].sr);
         chk($sformatf("tbl%0d_ser_valid", i), obs_v[0], tbl[i].v);
         chk($sformatf("tbl%0d_ser_out", i), obs_o[0], tbl[i].o);
         chk($sformatf("tbl%0d_ser_last", i), obs_l[0], tbl[i].l);
         chk($sformatf("tbl%0d_load_ready", i), obs_r[0], tbl[i].r);
      end

      // LSB-first 8'h01 on u1.
      step(1'b1, 8'h01, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 8'h00, 1'b1);
         chk($sformatf("lsb_bit%0d", i), obs_o[1], logic'(i == 0));
         chk($sformatf("lsb_last%0d", i), obs_l[1], logic'(i == 7));
      end
      step(1'b0, 8'h00, 1'b1);
      chk("lsb_idle_after", obs_v[1], 1'b0);

      // Backpressure: 3-cycle stall after the 2nd bit of 8'hC3.
      step(1'b1, 8'hC3, 1'b1);
      beats = 0;
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 8'h00, 1'b1);
         chk($sformatf("bp_bit%0d", i), obs_o[0], c3[7-i]);
         if (obs_v[0]) beats++;
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00, 1'b0);
         chk($sformatf("bp_stall%0d_out", i), obs_o[0], 1'b0);
         chk($sformatf("bp_stall%0d_valid", i), obs_v[0], 1'b1);
         chk($sformatf("bp_stall%0d_ready", i), obs_r[0], 1'b0);
      end
      for (int i = 2; i < 8; i++) begin
         step(1'b0, 8'h00, 1'b1);
         chk($sformatf("bp_bit%0d", i), obs_o[0], c3[7-i]);
         chk($sformatf("bp_last%0d", i), obs_l[0], logic'(i == 7));
         if (obs_v[0]) beats++;
      end
      chk_int("bp_beat_count", beats, 8);
      step(1'b0, 8'h00, 1'b1);
      chk("bp_idle_after", obs_v[0], 1'b0);

      // Back-to-back 8'hFF then 8'h00 with load_valid held.
      step(1'b1, 8'hFF, 1'b1);
      beats = 0; lasts = 0; readies = 0;
      for (int i = 0; i < 16; i++) begin
         step(logic'(i < 8), 8'h00, 1'b1);
         chk($sformatf("b2b_valid%0d", i), obs_v[0], 1'b1);
         chk($sformatf("b2b_bit%0d", i), obs_o[0], logic'(i < 8));
         chk($sformatf("b2b_ready%0d", i), obs_r[0], logic'(i == 7 || i == 15));
         if (obs_v[0]) beats++;
         if (obs_l[0]) lasts++;
         if (obs_r[0]) readies++;
      end
      chk_int("b2b_beats", beats, 16);
      chk_int("b2b_lasts", lasts, 2);
      chk_int("b2b_ready_pulses", readies, 2);
      step(1'b0, 8'h00, 1'b1);
      chk("b2b_idle_after", obs_v[0], 1'b0);

      // Async reset after the 3rd bit of 8'h5A, then a clean 8'h81.
      step(1'b1, 8'h5A, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_values("midword_reset");
      model_reset();
      step(1'b0, 8'h00, 1'b1);
      #2;
      rst_n = 1'b1;
      step(1'b1, 8'h81, 1'b1);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 8'h00, 1'b1);
         chk($sformatf("post_rst_bit%0d", i), obs_o[0], x81[7-i]);
         chk($sformatf("post_rst_last%0d", i), obs_l[0], logic'(i == 7));
      end

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++)
         step(1'($urandom_range(0, 1)), 8'($urandom), logic'($urandom_range(0, 3) != 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
